// File: rtl/traffic_light_monitor.sv
// Protocol monitor for the one-hot traffic light bus: locks onto RED->YELLOW->GREEN,
// measures phase dwell, flags illegal codes / ordering / dwell violations, counts cycles.
module traffic_light_monitor #(
  parameter int MIN_RED    = 1,
  parameter int MIN_YELLOW = 1,
  parameter int MIN_GREEN  = 1,
  parameter int MAX_DWELL  = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       light,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic [15:0]      cycle_cnt,
  output logic             code_err,
  output logic             seq_err,
  output logic             dwell_err,
  output logic             err_pulse
);

  typedef enum logic [1:0] {SYNC = 2'd0, RED = 2'd1, YELLOW = 2'd2, GREEN = 2'd3} phase_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  phase_t           state_q, state_d;
  phase_t           seen, expect_next;
  logic             legal;
  logic [CNT_W-1:0] min_cur, dwell_d;
  logic [15:0]      cycle_d;
  logic             code_hit, seq_hit, dwell_hit;

  assign phase = state_q;

  always_comb begin
    seen  = SYNC;
    legal = 1'b1;
    case (light)
      3'b100:  seen = RED;
      3'b010:  seen = YELLOW;
      3'b001:  seen = GREEN;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    expect_next = RED;
    min_cur     = CNT_W'(MIN_RED);
    case (state_q)
      RED:     begin expect_next = YELLOW; min_cur = CNT_W'(MIN_RED);    end
      YELLOW:  begin expect_next = GREEN;  min_cur = CNT_W'(MIN_YELLOW); end
      GREEN:   begin expect_next = RED;    min_cur = CNT_W'(MIN_GREEN);  end
      default: begin expect_next = RED;    min_cur = CNT_W'(MIN_RED);    end
    endcase
  end

  // Next-state and error detection; disabled monitor parks in SYNC and freezes counters.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_cnt;
    cycle_d   = cycle_cnt;
    code_hit  = 1'b0;
    seq_hit   = 1'b0;
    dwell_hit = 1'b0;
    if (!enable) begin
      state_d = SYNC;
    end else if (state_q == SYNC) begin
      if (legal && seen == RED) begin
        state_d = RED;
        dwell_d = ONE_C;
      end
    end else if (!legal) begin
      code_hit = 1'b1;
      state_d  = SYNC;
      dwell_d  = '0;
    end else if (seen == state_q) begin
      if (dwell_cnt < MAX_C) begin
        dwell_d   = dwell_cnt + ONE_C;
        dwell_hit = (dwell_d == MAX_C);
      end
    end else begin
      state_d = seen;
      dwell_d = ONE_C;
      if (seen == expect_next) begin
        dwell_hit = (dwell_cnt < min_cur);
        if (state_q == GREEN) cycle_d = cycle_cnt + 16'd1;
      end else begin
        seq_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      dwell_cnt <= '0;
      cycle_cnt <= '0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      dwell_err <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_cnt <= dwell_d;
      cycle_cnt <= cycle_d;
      // A fresh error in the clearing cycle keeps its flag set.
      code_err  <= code_hit  | (code_err  & ~clear_err);
      seq_err   <= seq_hit   | (seq_err   & ~clear_err);
      dwell_err <= dwell_hit | (dwell_err & ~clear_err);
      err_pulse <= code_hit | seq_hit | dwell_hit;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: two instances (default and MIN_GREEN=3) share stimulus
// and are compared every cycle against a behavioural model of the light protocol.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  localparam int MAXD = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear_err = 1'b0;
  logic [2:0] light = 3'b000;

  logic [1:0]  phase_a, phase_b;
  logic [7:0]  dwell_cnt_a, dwell_cnt_b;
  logic [15:0] cycle_cnt_a, cycle_cnt_b;
  logic        code_err_a, code_err_b, seq_err_a, seq_err_b;
  logic        dwell_err_a, dwell_err_b, err_pulse_a, err_pulse_b;

  int total = 0;
  int bad = 0;
  logic [29:0] exp_q[$];

  int m_phase[2], m_dwell[2], m_cycle[2];
  bit m_ce[2], m_se[2], m_de[2], m_pulse[2];
  int m_min[2][4] = '{'{0, 1, 1, 1}, '{0, 1, 1, 3}};

  always #5 clk = ~clk;

  traffic_light_monitor dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .light(light), .clear_err(clear_err),
    .phase(phase_a), .dwell_cnt(dwell_cnt_a), .cycle_cnt(cycle_cnt_a),
    .code_err(code_err_a), .seq_err(seq_err_a), .dwell_err(dwell_err_a), .err_pulse(err_pulse_a)
  );

  traffic_light_monitor #(.MIN_GREEN(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .light(light), .clear_err(clear_err),
    .phase(phase_b), .dwell_cnt(dwell_cnt_b), .cycle_cnt(cycle_cnt_b),
    .code_err(code_err_b), .seq_err(seq_err_b), .dwell_err(dwell_err_b), .err_pulse(err_pulse_b)
  );

  function automatic logic [29:0] obs(int k);
    if (k == 0)
      return {phase_a, dwell_cnt_a, cycle_cnt_a, code_err_a, seq_err_a, dwell_err_a, err_pulse_a};
    return {phase_b, dwell_cnt_b, cycle_cnt_b, code_err_b, seq_err_b, dwell_err_b, err_pulse_b};
  endfunction

  // Phases numbered 1=RED,2=YELLOW,3=GREEN; the successor of p is p%3+1.
  task automatic model_update(input logic [2:0] l, input logic en, input logic clr, input logic rst);
    for (int k = 0; k < 2; k++) begin
      bit ce = 0, se = 0, de = 0;
      int lp = ($countones(l) == 1) ? 3 - $clog2(l) : 0;
      if (rst) begin
        m_phase[k] = 0; m_dwell[k] = 0; m_cycle[k] = 0;
        m_ce[k] = 0; m_se[k] = 0; m_de[k] = 0; m_pulse[k] = 0;
        continue;
      end
      if (!en) begin
        m_phase[k] = 0;
      end else if (m_phase[k] == 0) begin
        if (lp == 1) begin m_phase[k] = 1; m_dwell[k] = 1; end
      end else if (lp == 0) begin
        ce = 1; m_phase[k] = 0; m_dwell[k] = 0;
      end else if (lp == m_phase[k]) begin
        if (m_dwell[k] < MAXD) begin
          m_dwell[k]++;
          de = (m_dwell[k] == MAXD);
        end
      end else begin
        if (lp == m_phase[k] % 3 + 1) begin
          de = (m_dwell[k] < m_min[k][m_phase[k]]);
          if (m_phase[k] == 3) m_cycle[k] = (m_cycle[k] + 1) % 65536;
        end else begin
          se = 1;
        end
        m_phase[k] = lp; m_dwell[k] = 1;
      end
      m_ce[k] = ce | (m_ce[k] & !clr);
      m_se[k] = se | (m_se[k] & !clr);
      m_de[k] = de | (m_de[k] & !clr);
      m_pulse[k] = ce | se | de;
    end
  endtask

  function automatic logic [5:0] ent(logic [2:0] l, logic clr = 1'b0, logic rst = 1'b0, logic en = 1'b1);
    return {rst, clr, en, l};
  endfunction

  // Entry layout {rst, clr, en, light}; inputs settle 1 time unit after the edge.
  task automatic step(input logic [5:0] e);
    light = e[2:0]; enable = e[3]; clear_err = e[4]; reset_n = ~e[5];
    @(posedge clk);
    model_update(e[2:0], e[3], e[4], e[5]);
    for (int k = 0; k < 2; k++)
      exp_q.push_back({2'(m_phase[k]), 8'(m_dwell[k]), 16'(m_cycle[k]),
                       m_ce[k], m_se[k], m_de[k], m_pulse[k]});
    #1;
  endtask

  task automatic test_reset();
    logic [29:0] e;
    for (int i = 0; i < 2; i++) begin
      step(ent(3'($urandom_range(0, 7)), 1'b1, 1'b1));
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== 30'd0 || e !== 30'd0) begin
          bad++;
          $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), 30'd0);
        end
      end
    end
  endtask

  task automatic test_cycles();
    logic [29:0] e;
    for (int i = 0; i < 9; i++) begin
      step(ent(R >> (i % 3)));
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL cycles dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
    end
    total++;
    if (cycle_cnt_a !== 16'd2 || err_pulse_a !== 1'b0) begin
      bad++;
      $display("FAIL cycles_count got=%0d exp=2", cycle_cnt_a);
    end
  endtask

  task automatic test_seq_err();
    logic [29:0] e;
    logic [5:0] tbl[3];
    tbl = '{ent(R), ent(G), ent(R)};
    for (int i = 0; i < 3; i++) begin
      step(tbl[i]);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL seq_err dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
    end
    total++;
    if (cycle_cnt_a !== 16'd4 || seq_err_a !== 1'b1) begin
      bad++;
      $display("FAIL seq_err_final got cyc=%0d seq=%b exp cyc=4 seq=1", cycle_cnt_a, seq_err_a);
    end
  endtask

  task automatic test_min_green();
    logic [29:0] e;
    logic [5:0] tbl[5];
    tbl = '{ent(R, 1'b1), ent(Y), ent(G), ent(G), ent(R)};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i]);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL min_green dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
    end
    total++;
    if (dwell_err_b !== 1'b1 || dwell_err_a !== 1'b0 || cycle_cnt_b !== 16'd5) begin
      bad++;
      $display("FAIL min_green_flags got b=%b a=%b cyc=%0d exp b=1 a=0 cyc=5",
               dwell_err_b, dwell_err_a, cycle_cnt_b);
    end
  endtask

  task automatic test_saturation();
    logic [29:0] e;
    for (int i = 0; i < 13; i++) begin
      step(i == 0 ? ent(R, 1'b1) : ent(Y));
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL saturation dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
    end
    total++;
    if (dwell_cnt_a !== 8'd8 || dwell_err_a !== 1'b1) begin
      bad++;
      $display("FAIL saturation_final got dwell=%0d err=%b exp dwell=8 err=1", dwell_cnt_a, dwell_err_a);
    end
  endtask

  task automatic test_code_err();
    logic [29:0] e;
    logic [5:0] tbl[4];
    tbl = '{ent(3'b110), ent(Y), ent(G), ent(R)};
    for (int i = 0; i < 4; i++) begin
      step(tbl[i]);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL code_err dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
    end
    total++;
    if (phase_a !== 2'd1 || dwell_cnt_a !== 8'd1 || code_err_a !== 1'b1) begin
      bad++;
      $display("FAIL code_err_final got ph=%0d dw=%0d ce=%b exp ph=1 dw=1 ce=1",
               phase_a, dwell_cnt_a, code_err_a);
    end
  endtask

  task automatic test_clear_and_reset();
    logic [29:0] e;
    logic [5:0] tbl[6];
    tbl = '{ent(G), ent(Y, 1'b1), ent(Y, 1'b1), ent(G), ent(G), ent(G, 1'b0, 1'b1)};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i]);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL clear dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
      if (i == 1) begin
        total++;
        if (seq_err_a !== 1'b1) begin
          bad++;
          $display("FAIL clear_vs_new got seq=%b exp=1", seq_err_a);
        end
      end
    end
    total++;
    if (obs(0) !== 30'd0 || obs(1) !== 30'd0) begin
      bad++;
      $display("FAIL mid_green_reset got a=%h b=%h exp=0", obs(0), obs(1));
    end
  endtask

  task automatic test_random();
    logic [29:0] e;
    logic [2:0] l;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)
        l = (m_phase[0] == 0) ? R : R >> ((m_phase[0] - 1 + $urandom_range(0, 1)) % 3);
      else if (r < 8)
        l = R >> $urandom_range(0, 2);
      else
        l = 3'($urandom_range(0, 7));
      step(ent(l, $urandom_range(0, 15) == 0, $urandom_range(0, 127) == 0,
               $urandom_range(0, 15) != 0));
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++;
          $display("FAIL random dut%0d step%0d got=%h exp=%h", k, i, obs(k), e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cycles();
    test_seq_err();
    test_min_green();
    test_saturation();
    test_code_err();
    test_clear_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Receive-side checker for the 3-bit one-hot traffic light code (RED=3'b100, YELLOW=3'b010, GREEN=3'b001) driven by the traffic light controller. It samples the light bus every clock and locks onto the RED→YELLOW→GREEN→RED sequence. It measures the dwell time of each phase and raises sticky error flags for illegal codes, out-of-order phases and dwell violations. It sits beside the controller as an on-chip protocol monitor and counts completed light cycles.

Parameters:
MIN_RED, 1, minimum legal RED dwell in clocks (1..2^CNT_W-1)
MIN_YELLOW, 1, minimum legal YELLOW dwell in clocks
MIN_GREEN, 1, minimum legal GREEN dwell in clocks
MAX_DWELL, 8, maximum legal dwell of any phase in clocks (≥ every MIN_*, < 2^CNT_W)
CNT_W, 8, width of dwell counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
enable  input  1  1 = monitor active; 0 = return to SYNC, hold counters and flags
light  input  3  light code from the controller, sampled on every rising clk edge
clear_err  input  1  synchronous clear of the sticky error flags
phase  output  2  tracked phase: 0=SYNC, 1=RED, 2=YELLOW, 3=GREEN
dwell_cnt  output  CNT_W  clocks spent in the current phase, saturating at MAX_DWELL
cycle_cnt  output  16  completed GREEN→RED transitions, wraps 16'hFFFF→0
code_err  output  1  sticky: non-one-hot code seen while tracking
seq_err  output  1  sticky: legal code out of order
dwell_err  output  1  sticky: phase ended before MIN_* or reached MAX_DWELL
err_pulse  output  1  one-clock pulse on any newly detected error

Behaviour:
- Reset (reset_n=0 at a clk edge): phase=SYNC, dwell_cnt=0, cycle_cnt=0, all error flags=0, err_pulse=0. Reset overrides enable and clear_err. Reset mid-sequence discards all tracking.
- All outputs are registered. The light value sampled at edge N is reflected in the outputs after edge N, so latency is 1 clock.
- "Expected next" phase: RED→YELLOW, YELLOW→GREEN, GREEN→RED. MIN(X) is MIN_RED, MIN_YELLOW or MIN_GREEN according to the tracked phase X.
- SYNC:
  - Wait for light==RED, then go to RED with dwell_cnt=1.
  - Every other code, legal or illegal, is ignored and raises no error.
- Tracking in phase X:
  - light==X: dwell_cnt increments, saturating at MAX_DWELL.
  - dwell_cnt reaching MAX_DWELL sets dwell_err and pulses err_pulse once. No repeat pulse while saturated.
  - light==next(X): go to next(X) with dwell_cnt=1.
    - If the old dwell_cnt < MIN(X), set dwell_err and pulse err_pulse.
    - If the transition is GREEN→RED, cycle_cnt increments.
  - light is the other legal one-hot code (the skip or reverse case): set seq_err and pulse err_pulse. Adopt the observed phase with dwell_cnt=1. cycle_cnt is unchanged.
  - light not one-hot (000, 011, 101, 110, 111): set code_err, pulse err_pulse, go to SYNC with dwell_cnt=0.
- Simultaneous events in one cycle: more than one error flag may be set, and err_pulse is still a single-cycle high.
- clear_err=1 clears code_err, seq_err and dwell_err. A new error detected in the same cycle wins and the flag stays set. clear_err does not affect phase or the counters.
- enable=0:
  - Next state is SYNC. dwell_cnt, cycle_cnt and the flags hold their values.
  - No errors are detected and err_pulse=0.
  - On re-enable, resync starts from SYNC. dwell_cnt is reloaded at lock.
- err_pulse deasserts the clock after it is asserted unless a new error is detected.
- dwell_cnt never exceeds MAX_DWELL and never wraps.

Test Plan:
1. Reset, then enable=1 and light RED,YELLOW,GREEN repeated for 3 full cycles at 1 clk/phase (default params) → phase tracks 1,2,3, dwell_cnt=1 each cycle, cycle_cnt=2 after the last RED seen, all flags 0, err_pulse never high.
2. Locked in RED, drive light=GREEN → seq_err=1, err_pulse high for exactly 1 clk, phase=3, dwell_cnt=1; then drive RED → cycle_cnt increments.
3. MIN_GREEN=3: drive GREEN for 2 clks then RED → dwell_err=1 and one err_pulse at the RED transition, cycle_cnt still increments.
4. Hold YELLOW for 12 clks (MAX_DWELL=8) → dwell_cnt saturates at 8, dwell_err set when the count reaches 8, a single err_pulse.
5. While locked, drive light=3'b110 → code_err=1, phase=0; subsequent YELLOW/GREEN ignored with no new pulse; RED → phase=1, dwell_cnt=1.
6. With seq_err=1, assert clear_err in the same cycle as a new out-of-order code → seq_err stays 1. Assert clear_err alone → all flags 0. Drive reset_n=0 mid-GREEN → all outputs return to reset values on the next edge.
